id_hazard_scoreboard: RTL

Parametrised ID-stage hazard and forwarding unit for the pipelined CPU. It keeps its own shadow pipeline of in-flight destination registers instead of taking per-stage write-enables from outside. From that shadow it produces per-read-port forward selects for ID-stage operand muxes, including branch compare. It also produces load-use stall requests and a saturating stall-cycle counter. It sits beside the ID/EXE pipeline register and is advanced by the same stall, flush and freeze controls.

---
 rtl/id_hazard_scoreboard.sv | 79 +++++++
 1 files changed

// File: rtl/id_hazard_scoreboard.sv
// ID-stage hazard/forwarding unit: shadows in-flight destinations after ID,
// derives per-port forward selects, load-use stalls and a stall counter.
module id_hazard_scoreboard #(
    parameter int DEPTH      = 3,
    parameter int NUM_RD     = 2,
    parameter int LOAD_READY = 3,
    parameter int CNT_W      = 16,
    parameter int SEL_W      = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    id_valid,
    input  logic                    id_RegWrite,
    input  logic                    id_MemRead,
    input  logic [4:0]              id_RegisterRd,
    input  logic [5*NUM_RD-1:0]     id_RFR,
    input  logic [NUM_RD-1:0]       id_RFUse,
    input  logic                    freeze,
    input  logic                    flush,
    output logic [SEL_W*NUM_RD-1:0] ForwardSel,
    output logic                    stall,
    output logic [CNT_W-1:0]        stall_cnt
);

    logic       r_v  [DEPTH:1];
    logic       r_wr [DEPTH:1];
    logic       r_ld [DEPTH:1];
    logic [4:0] r_rd [DEPTH:1];

    logic [CNT_W-1:0]  r_cnt;
    logic [NUM_RD-1:0] w_haz;
    logic              w_stall;

    // Scan oldest to nearest so the nearest producer overrides older ones.
    always_comb begin
        ForwardSel = '0;
        w_haz      = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            for (int s = DEPTH; s >= 1; s--) begin
                if (r_v[s] && r_wr[s] && (r_rd[s] != 5'd0) &&
                    (r_rd[s] == id_RFR[5*k +: 5]) && id_RFUse[k]) begin
                    ForwardSel[SEL_W*k +: SEL_W] = SEL_W'(s);
                    w_haz[k] = r_ld[s] && (s < LOAD_READY);
                end
            end
        end
    end

    assign w_stall   = id_valid && (|w_haz) && !flush && !freeze;
    assign stall     = w_stall;
    assign stall_cnt = r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 1; s <= DEPTH; s++) begin
                r_v[s]  <= 1'b0;
                r_wr[s] <= 1'b0;
                r_ld[s] <= 1'b0;
                r_rd[s] <= 5'd0;
            end
            r_cnt <= '0;
        end else if (!freeze) begin
            for (int s = DEPTH; s >= 2; s--) begin
                r_v[s]  <= r_v[s-1];
                r_wr[s] <= r_wr[s-1];
                r_ld[s] <= r_ld[s-1];
                r_rd[s] <= r_rd[s-1];
            end
            r_v[1]  <= id_valid && !w_stall && !flush;
            r_wr[1] <= id_RegWrite;
            r_ld[1] <= id_MemRead;
            r_rd[1] <= id_RegisterRd;
            if (w_stall && (r_cnt != {CNT_W{1'b1}})) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule
